// File: rtl/reg_op_pkg.sv
// ---------------------------------------------------------------------------
// reg_op_pkg
//
// Shared definitions for the register-operation sequencer and its command
// FIFO.
//
// Contents:
//   reg_op_t     - one register operation as driven onto the register block
//                  {load, s[1:0], data[3:0]}, 7 bits, load in the MSB
//   IDLE_OP      - the operation value driven whenever no command is active
//   seq_state_t  - sequencer FSM states {IDLE, ISSUE, SETTLE, RESP}
//   cmd_width()  - width of one queued command for a given repeat-field width
//   cmd_op_lsb() - bit offset of the reg_op_t field inside a queued command
//
// Queued command layout (MSB -> LSB):
//   [cnt_w+6]            load
//   [cnt_w+5 : cnt_w+4]  s
//   [cnt_w+3 : cnt_w]    data
//   [cnt_w-1 : 0]        cnt (repeat count minus one)
// ---------------------------------------------------------------------------
package reg_op_pkg;

  // Width of the operation part of a command (load + s + data).
  localparam int OP_W = 7;

  // Bit offset of the repeat count inside a command; it sits at the bottom.
  localparam int CMD_CNT_LSB = 0;

  typedef struct packed {
    logic       load;
    logic [1:0] s;
    logic [3:0] data;
  } reg_op_t;

  // Value presented to the register block between operations: no load,
  // op-select 00 (hold), data zero.
  localparam reg_op_t IDLE_OP = 7'b0_00_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } seq_state_t;

  // Total command width: operation bits plus the repeat field.
  function automatic int cmd_width(input int cnt_w);
    return OP_W + cnt_w;
  endfunction

  // The operation field starts directly above the repeat count.
  function automatic int cmd_op_lsb(input int cnt_w);
    return CMD_CNT_LSB + cnt_w;
  endfunction

endpackage

// File: rtl/reg_op_cmd_fifo.sv
// ---------------------------------------------------------------------------
// reg_op_cmd_fifo
//
// Small synchronous FIFO that queues register-operation commands between the
// command port and the sequencer FSM. There is no bypass path: an entry
// written on one edge is visible at pop_data only after that edge, so a
// command entering an empty FIFO can be popped on the following edge at the
// earliest.
//
// Parameters:
//   DEPTH  - number of entries, power of two, at least 2
//   CMD_W  - width of one entry
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset; flushes the FIFO
//   push       in   write push_data this edge (ignored while full)
//   push_data  in   entry to write
//   pop        in   discard the head entry this edge (ignored while empty)
//   pop_data   out  current head entry (undefined content while empty)
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
// ---------------------------------------------------------------------------
module reg_op_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  // One extra bit so that "full" (== DEPTH) is distinguishable from empty.
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q,  count_d;

  logic push_ok;
  logic pop_ok;

  assign full  = (count_q == DEPTH_OCC);
  assign empty = (count_q == '0);

  // Writes into a full FIFO and reads from an empty one are dropped so the
  // stored contents can never be corrupted by a stray strobe.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign pop_data = mem_q[rd_ptr_q];

  // Pointers wrap modulo DEPTH on their own because DEPTH is a power of two.
  // A simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// reg_op_sequencer
//
// Command-driven initiator for the 4-bit operation register interface
// (load, s[1:0], reg_in[3:0] -> reg_out[3:0]). Commands are queued over a
// valid/ready port, each one is driven onto the register block for cnt+1
// cycles, the register output is sampled after one settle cycle, and the
// sampled value is returned on a valid/ready response port. Responses come
// back strictly in command order.
//
// Parameters:
//   DEPTH  - command FIFO entries (power of two, at least 2)
//   CNT_W  - width of the repeat field; an operation is driven cnt+1 cycles
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset; aborts any operation
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted on cmd_valid && cmd_ready at the edge
//   cmd_load   in   load value to drive
//   cmd_s      in   op-select value to drive
//   cmd_data   in   reg_in value to drive
//   cmd_cnt    in   repeat count minus one
//   load       out  register load strobe, registered
//   s          out  register op select, registered
//   reg_in     out  register data input, registered
//   reg_out    in   register data output, sampled after the settle cycle
//   rsp_valid  out  response present
//   rsp_ready  in   response consumed on rsp_valid && rsp_ready at the edge
//   rsp_data   out  captured reg_out
//   busy       out  FSM not idle or commands still queued
// ---------------------------------------------------------------------------
module reg_op_sequencer
  import reg_op_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_s,
  input  logic [3:0]       cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             load,
  output logic [1:0]       s,
  output logic [3:0]       reg_in,
  input  logic [3:0]       reg_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_data,
  output logic             busy
);

  localparam int CMD_W  = cmd_width(CNT_W);
  localparam int OP_LSB = cmd_op_lsb(CNT_W);

  // Command FIFO interface
  logic             fifo_push;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_push_data;
  logic [CMD_W-1:0] fifo_pop_data;
  logic             fifo_full;
  logic             fifo_empty;

  // Head-of-queue command split into its fields
  reg_op_t          head_op;
  logic [CNT_W-1:0] head_cnt;

  // FSM and output registers
  seq_state_t       state_q,     state_d;
  reg_op_t          op_q,        op_d;
  logic [CNT_W-1:0] rep_q,       rep_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [3:0]       rsp_data_q,  rsp_data_d;

  // cmd_ready is forced low while reset is held so nothing is accepted into
  // a FIFO that is being flushed.
  assign cmd_ready      = reset && !fifo_full;
  assign fifo_push      = cmd_valid && cmd_ready;
  assign fifo_push_data = {cmd_load, cmd_s, cmd_data, cmd_cnt};

  reg_op_cmd_fifo #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W)
  ) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_op  = reg_op_t'(fifo_pop_data[CMD_W-1:OP_LSB]);
  assign head_cnt = fifo_pop_data[OP_LSB-1:CMD_CNT_LSB];

  // Operation fields go to the register block undecoded.
  assign load      = op_q.load;
  assign s         = op_q.s;
  assign reg_in    = op_q.data;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  assign busy = (state_q != IDLE) || !fifo_empty;

  // Next-state logic. An operation occupies the register block for rep+1
  // ISSUE cycles: the op is loaded when leaving IDLE together with rep, and
  // the edge that sees rep==0 replaces it with the idle value. SETTLE gives
  // the register one quiet cycle so reg_out reflects the last op edge before
  // it is captured. RESP then holds the captured value until the consumer
  // takes it; the FSM does not pop the next command until it is back in
  // IDLE, which keeps responses in command order.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rep_d       = rep_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        op_d = IDLE_OP;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = head_op;
          rep_d    = head_cnt;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        if (rep_q == '0) begin
          op_d    = IDLE_OP;
          state_d = SETTLE;
        end else begin
          rep_d = rep_q - CNT_W'(1);
        end
      end

      SETTLE: begin
        rsp_data_d  = reg_out;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        op_d        = IDLE_OP;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // All FSM state and every registered output update together; reset puts
  // the register block back at the idle op immediately and drops any
  // pending response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= IDLE_OP;
      rep_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rep_q       <= rep_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_op_sequencer
//
// Directed bench for reg_op_sequencer. A behavioural 4-bit register sits on
// the load/s/reg_in/reg_out interface; inputs are driven and outputs sampled
// on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_reg_op_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_load = 1'b0;
  logic [1:0]       cmd_s = 2'b00;
  logic [3:0]       cmd_data = 4'h0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic             load;
  logic [1:0]       s;
  logic [3:0]       reg_in;
  logic [3:0]       reg_out = 4'h0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [3:0]       rsp_data;
  logic             busy;

  int assertCount = 0;
  int failCount   = 0;

  reg_op_sequencer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_s     (cmd_s),
    .cmd_data  (cmd_data),
    .cmd_cnt   (cmd_cnt),
    .load      (load),
    .s         (s),
    .reg_in    (reg_in),
    .reg_out   (reg_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Behavioural register block: load wins, s==01 increments, else hold.
  always @(posedge clk) begin
    if (load) begin
      reg_out <= reg_in;
    end else if (s == 2'b01) begin
      reg_out <= reg_out + 4'd1;
    end
  end

  // Safety net so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", tag, actual, expected);
    end
  endtask

  // Present a command from a falling edge and wait until it is accepted.
  // Returns on the falling edge after the accepting rising edge with
  // cmd_valid still high; the caller drops it or presents the next one.
  task automatic applyStimulus(input logic ld, input logic [1:0] sv,
                               input logic [3:0] dv, input logic [CNT_W-1:0] cv,
                               input string tag);
    bit accepted;
    accepted  = 1'b0;
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_s     = sv;
    cmd_data  = dv;
    cmd_cnt   = cv;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (cmd_ready) accepted = 1'b1;
      @(negedge clk);
    end
    checkOutput({tag, "_accept"}, 32'(accepted), 32'd1);
  endtask

  // Wait (bounded) for a response, check its data, and let it be consumed.
  task automatic waitResponse(input logic [3:0] expData, input string tag);
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    if (rsp_valid) begin
      checkOutput({tag, "_data"}, 32'(rsp_data), 32'(expData));
      @(negedge clk);
    end
  endtask

  // Issue one command, count how many sampled cycles show its op, then
  // collect and check the response.
  task automatic runOp(input logic ld, input logic [1:0] sv, input logic [3:0] dv,
                       input logic [CNT_W-1:0] cv, input int expCycles,
                       input logic [3:0] expRsp, input string tag);
    int cycles;
    cycles    = 0;
    rsp_ready = 1'b1;
    applyStimulus(ld, sv, dv, cv, tag);
    cmd_valid = 1'b0;
    for (int i = 0; i < 40 && !rsp_valid; i++) begin
      if (load == ld && s == sv && reg_in == dv) cycles++;
      @(negedge clk);
    end
    checkOutput({tag, "_cycles"}, 32'(cycles), 32'(expCycles));
    waitResponse(expRsp, tag);
  endtask

  initial begin
    bit sawRsp;

    // Reset held low from time zero for 12.5 ns.
    #8;
    checkOutput("rst_op",    32'({load, s, reg_in}), 32'h0);
    checkOutput("rst_rsp",   32'({rsp_valid, rsp_data}), 32'h0);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
    #4.5;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("post_rst_busy",  32'(busy), 32'd0);

    // Single load of 5 with cnt=0: exact edge-by-edge latency.
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 2'b11, 4'h5, 3'd0, "t2");
    cmd_valid = 1'b0;
    checkOutput("t2_e0_busy", 32'(busy), 32'd1);
    checkOutput("t2_e0_op",   32'({load, s, reg_in}), 32'h0);
    @(negedge clk);
    checkOutput("t2_e1_op",   32'({load, s, reg_in}), 32'h75);
    checkOutput("t2_e1_rsp",  32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("t2_e2_op",   32'({load, s, reg_in}), 32'h0);
    checkOutput("t2_e2_rsp",  32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("t2_e3_rsp",  32'({rsp_valid, rsp_data}), 32'h15);
    @(negedge clk);
    checkOutput("t2_e4_rsp",  32'(rsp_valid), 32'd0);
    checkOutput("t2_e4_busy", 32'(busy), 32'd0);

    // Clear the register, then increment for cnt+1 = 4 cycles.
    runOp(1'b1, 2'b00, 4'h0, 3'd0, 1, 4'h0, "t3_load");
    runOp(1'b0, 2'b01, 4'h0, 3'd3, 4, 4'h4, "t3_inc");

    // Back-to-back loads 6..A with the response port stalled.
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 2'b10, 4'(6 + k), 3'd0, $sformatf("t4_push%0d", k));
    end
    cmd_valid = 1'b0;
    checkOutput("t4_full_ready", 32'(cmd_ready), 32'd0);
    checkOutput("t4_full_busy",  32'(busy), 32'd1);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t4_stall%0d", i), 32'({rsp_valid, rsp_data}), 32'h16);
      @(negedge clk);
    end
    checkOutput("t4_stall_ready", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      waitResponse(4'(6 + k), $sformatf("t4_rsp%0d", k));
    end
    checkOutput("t4_done_busy", 32'(busy), 32'd0);

    // Abort a long increment with reset in its third ISSUE cycle.
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 2'b01, 4'h0, 3'd7, "t5");
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t5_before_op", 32'({load, s, reg_in}), 32'h10);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5_async_op",    32'({load, s, reg_in}), 32'h0);
    checkOutput("t5_async_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sawRsp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) sawRsp = 1'b1;
    end
    checkOutput("t5_no_rsp", 32'(sawRsp), 32'd0);
    checkOutput("t5_busy",   32'(busy), 32'd0);
    checkOutput("t5_ready",  32'(cmd_ready), 32'd1);

    // Maximum repeat count: 8 cycles, no wrap, exactly one response.
    runOp(1'b1, 2'b00, 4'h0, 3'd0, 1, 4'h0, "t6_load");
    runOp(1'b0, 2'b01, 4'h0, 3'd7, 8, 4'h8, "t6_inc");
    sawRsp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) sawRsp = 1'b1;
    end
    checkOutput("t6_single_rsp", 32'(sawRsp), 32'd0);
    checkOutput("t6_busy",       32'(busy), 32'd0);
    checkOutput("t6_idle_op",    32'({load, s, reg_in}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
